// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default bus widths and the memory-controller channel state encoding.
package gpu_pkg;

  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_ctrl_channel.sv
// One memory channel: FSM plus latched request, serving a single consumer at a time.
// Write path (WRITE_* states and registers) exists only when MEM_CTRL_WRITE_EN is defined.
module mem_ctrl_channel import gpu_pkg::*; #(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CW        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 claim,
  input  logic                 claim_write,
  input  logic [CW-1:0]        claim_consumer,
  input  logic [ADDR_BITS-1:0] claim_address,
  input  logic [DATA_BITS-1:0] claim_data,
  input  logic                 served_read_valid,
  input  logic                 served_write_valid,
  output logic                 busy,
  output logic [CW-1:0]        consumer,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic                 read_relay,
  output logic                 write_relay,
  output logic [DATA_BITS-1:0] relay_data
);

  mem_ctrl_state_t      state_q, state_d;
  logic [CW-1:0]        cons_q, cons_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d, rrelay_q, rrelay_d;
`ifdef MEM_CTRL_WRITE_EN
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 wvalid_q, wvalid_d, wrelay_q, wrelay_d;
`endif

  always_comb begin
    state_d  = state_q;
    cons_d   = cons_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rrelay_d = rrelay_q;
`ifdef MEM_CTRL_WRITE_EN
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    wrelay_d = wrelay_q;
`endif
    case (state_q)
      IDLE: if (claim) begin
        cons_d = claim_consumer;
`ifdef MEM_CTRL_WRITE_EN
        if (claim_write) begin
          state_d  = WRITE_WAITING;
          wvalid_d = 1'b1;
          waddr_d  = claim_address;
          wdata_d  = claim_data;
        end else
`endif
        begin
          state_d  = READ_WAITING;
          rvalid_d = 1'b1;
          raddr_d  = claim_address;
        end
      end
      READ_WAITING: if (mem_read_ready) begin
        state_d  = READ_RELAYING;
        rvalid_d = 1'b0;
        rdata_d  = mem_read_data;
        rrelay_d = 1'b1;
      end
      READ_RELAYING: if (!served_read_valid) begin
        state_d  = IDLE;
        rrelay_d = 1'b0;
        rdata_d  = '0;
      end
`ifdef MEM_CTRL_WRITE_EN
      WRITE_WAITING: if (mem_write_ready) begin
        state_d  = WRITE_RELAYING;
        wvalid_d = 1'b0;
        wrelay_d = 1'b1;
      end
      WRITE_RELAYING: if (!served_write_valid) begin
        state_d  = IDLE;
        wrelay_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cons_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rrelay_q <= 1'b0;
`ifdef MEM_CTRL_WRITE_EN
      waddr_q  <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      wrelay_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cons_q   <= cons_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rrelay_q <= rrelay_d;
`ifdef MEM_CTRL_WRITE_EN
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wrelay_q <= wrelay_d;
`endif
    end
  end

  assign busy             = (state_q != IDLE);
  assign consumer         = cons_q;
  assign mem_read_valid   = rvalid_q;
  assign mem_read_address = raddr_q;
  assign read_relay       = rrelay_q;
  assign relay_data       = rdata_q;

`ifdef MEM_CTRL_WRITE_EN
  assign mem_write_valid   = wvalid_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdata_q;
  assign write_relay       = wrelay_q;
`else
  // Read-only build: the write-side inputs are deliberately ignored.
  logic unused_write;
  assign unused_write      = ^{claim_write, claim_data, served_write_valid, mem_write_ready};
  assign mem_write_valid   = 1'b0;
  assign mem_write_address = '0;
  assign mem_write_data    = '0;
  assign write_relay       = 1'b0;
`endif

endmodule

// File: rtl/mem_controller.sv
// Arbitrates LSU load/store requests onto NUM_CHANNELS single-outstanding memory channels.
// Define MEM_CTRL_WRITE_EN to build the write path; otherwise the controller is read-only.
module mem_controller import gpu_pkg::*; #(
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  logic [NUM_CHANNELS-1:0]                ch_claim, ch_claim_write, ch_busy;
  logic [NUM_CHANNELS-1:0][CW-1:0]        ch_claim_cons, ch_cons;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_claim_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_claim_data, ch_relay_data;
  logic [NUM_CHANNELS-1:0]                ch_srv_rv, ch_srv_wv, ch_rrelay, ch_wrelay;
  logic [NUM_CONSUMERS-1:0]               req, taken;
  logic                                   found;

`ifdef MEM_CTRL_WRITE_EN
  assign req = consumer_read_valid | consumer_write_valid;
`else
  assign req = consumer_read_valid;
`endif

  // Channels resolve in index order; each claim marks the consumer taken so
  // higher channels skip it within the same cycle.
  always_comb begin
    taken          = '0;
    found          = 1'b0;
    ch_claim       = '0;
    ch_claim_write = '0;
    ch_claim_cons  = '0;
    ch_claim_addr  = '0;
    ch_claim_data  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_busy[c]) taken[ch_cons[c]] = 1'b1;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      if (!ch_busy[c]) begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          if (!found && !taken[i] && req[i]) begin
            found             = 1'b1;
            taken[i]          = 1'b1;
            ch_claim[c]       = 1'b1;
            ch_claim_write[c] = !consumer_read_valid[i];
            ch_claim_cons[c]  = CW'(i);
            ch_claim_addr[c]  = consumer_read_valid[i] ? consumer_read_address[i*ADDR_BITS +: ADDR_BITS]
                                                       : consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
            ch_claim_data[c]  = consumer_write_data[i*DATA_BITS +: DATA_BITS];
          end
        end
      end
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_rrelay[c]) begin
        consumer_read_ready[ch_cons[c]] = 1'b1;
        consumer_read_data[int'(ch_cons[c])*DATA_BITS +: DATA_BITS] = ch_relay_data[c];
      end
      if (ch_wrelay[c]) consumer_write_ready[ch_cons[c]] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign ch_srv_rv[g] = consumer_read_valid[ch_cons[g]];
    assign ch_srv_wv[g] = consumer_write_valid[ch_cons[g]];

    mem_ctrl_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .CW       (CW)
    ) u_ch (
      .clk               (clk),
      .reset             (reset),
      .claim             (ch_claim[g]),
      .claim_write       (ch_claim_write[g]),
      .claim_consumer    (ch_claim_cons[g]),
      .claim_address     (ch_claim_addr[g]),
      .claim_data        (ch_claim_data[g]),
      .served_read_valid (ch_srv_rv[g]),
      .served_write_valid(ch_srv_wv[g]),
      .busy              (ch_busy[g]),
      .consumer          (ch_cons[g]),
      .mem_read_valid    (mem_read_valid[g]),
      .mem_read_address  (mem_read_address[g*ADDR_BITS +: ADDR_BITS]),
      .mem_read_ready    (mem_read_ready[g]),
      .mem_read_data     (mem_read_data[g*DATA_BITS +: DATA_BITS]),
      .mem_write_valid   (mem_write_valid[g]),
      .mem_write_address (mem_write_address[g*ADDR_BITS +: ADDR_BITS]),
      .mem_write_data    (mem_write_data[g*DATA_BITS +: DATA_BITS]),
      .mem_write_ready   (mem_write_ready[g]),
      .read_relay        (ch_rrelay[g]),
      .write_relay       (ch_wrelay[g]),
      .relay_data        (ch_relay_data[g])
    );
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench: a one-channel and a two-channel controller, table vectors plus corner sequences.
module tb_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // single-channel instance
  logic [3:0]  rv = '0, crr, wv = '0, cwr;
  logic [31:0] raddr = '0, crd, waddr = '0, wdata = '0;
  logic        mrv, mrr = 1'b0, mwv, mwr = 1'b0;
  logic [7:0]  mra, mrd = '0, mwa, mwd;

  // two-channel instance
  logic [3:0]  b_rv = '0, b_crr, b_wv = '0, b_cwr;
  logic [31:0] b_raddr = '0, b_crd, b_waddr = '0, b_wdata = '0;
  logic [1:0]  b_mrv, b_mrr = '0, b_mwv, b_mwr = '0;
  logic [15:0] b_mra, b_mrd = '0, b_mwa, b_mwd;

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(raddr),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(waddr),
    .consumer_write_data(wdata), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_raddr),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_waddr),
    .consumer_write_data(b_wdata), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra), .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] raddr;
    logic        mrr;
    logic [7:0]  mrd;
    logic        exp_mrv;
    logic [7:0]  exp_mra;
    logic [3:0]  exp_crr;
    logic [31:0] exp_crd;
  } vec_t;

  vec_t vecs[23];

  initial begin
    // consumer 2 reads 0x1A, memory answers 0x5C, release after valid drops
    vecs[0]  = '{4'b0100, 32'h001A0000, 1'b0, 8'h00, 1'b1, 8'h1A, 4'b0000, 32'h0};
    vecs[1]  = '{4'b0100, 32'h001A0000, 1'b1, 8'h5C, 1'b0, 8'h1A, 4'b0100, 32'h005C0000};
    vecs[2]  = '{4'b0100, 32'h001A0000, 1'b0, 8'h00, 1'b0, 8'h1A, 4'b0100, 32'h005C0000};
    vecs[3]  = '{4'b0000, 32'h001A0000, 1'b0, 8'h00, 1'b0, 8'h1A, 4'b0000, 32'h0};
    // consumers 0,1,3 together: served in index order, one at a time
    vecs[4]  = '{4'b1011, 32'h13001110, 1'b0, 8'h00, 1'b1, 8'h10, 4'b0000, 32'h0};
    vecs[5]  = '{4'b1011, 32'h13001110, 1'b1, 8'hA0, 1'b0, 8'h10, 4'b0001, 32'h000000A0};
    vecs[6]  = '{4'b1010, 32'h13001110, 1'b0, 8'h00, 1'b0, 8'h10, 4'b0000, 32'h0};
    vecs[7]  = '{4'b1010, 32'h13001110, 1'b0, 8'h00, 1'b1, 8'h11, 4'b0000, 32'h0};
    vecs[8]  = '{4'b1010, 32'h13001110, 1'b1, 8'hA1, 1'b0, 8'h11, 4'b0010, 32'h0000A100};
    vecs[9]  = '{4'b1000, 32'h13001110, 1'b0, 8'h00, 1'b0, 8'h11, 4'b0000, 32'h0};
    vecs[10] = '{4'b1000, 32'h13001110, 1'b0, 8'h00, 1'b1, 8'h13, 4'b0000, 32'h0};
    vecs[11] = '{4'b1000, 32'h13001110, 1'b1, 8'hA3, 1'b0, 8'h13, 4'b1000, 32'hA3000000};
    vecs[12] = '{4'b0000, 32'h13001110, 1'b0, 8'h00, 1'b0, 8'h13, 4'b0000, 32'h0};
    // consumer holds valid 4 cycles past ready; memory data bus changes meanwhile
    vecs[13] = '{4'b0001, 32'h00000022, 1'b0, 8'h00, 1'b1, 8'h22, 4'b0000, 32'h0};
    vecs[14] = '{4'b0001, 32'h00000022, 1'b1, 8'h99, 1'b0, 8'h22, 4'b0001, 32'h00000099};
    vecs[15] = '{4'b0001, 32'h00000022, 1'b0, 8'hFF, 1'b0, 8'h22, 4'b0001, 32'h00000099};
    vecs[16] = '{4'b0001, 32'h00000022, 1'b0, 8'hFF, 1'b0, 8'h22, 4'b0001, 32'h00000099};
    vecs[17] = '{4'b0001, 32'h00000022, 1'b0, 8'hFF, 1'b0, 8'h22, 4'b0001, 32'h00000099};
    vecs[18] = '{4'b0001, 32'h00000022, 1'b0, 8'hFF, 1'b0, 8'h22, 4'b0001, 32'h00000099};
    vecs[19] = '{4'b0000, 32'h00000022, 1'b0, 8'h00, 1'b0, 8'h22, 4'b0000, 32'h0};
    vecs[20] = '{4'b0001, 32'h00000023, 1'b0, 8'h00, 1'b1, 8'h23, 4'b0000, 32'h0};
    vecs[21] = '{4'b0001, 32'h00000023, 1'b1, 8'h42, 1'b0, 8'h23, 4'b0001, 32'h00000042};
    vecs[22] = '{4'b0000, 32'h00000023, 1'b0, 8'h00, 1'b0, 8'h23, 4'b0000, 32'h0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst mrv", {31'b0, mrv}, 32'h0);
    chk("rst mra", {24'b0, mra}, 32'h0);
    chk("rst crr", {28'b0, crr}, 32'h0);
    chk("rst crd", crd, 32'h0);
    chk("rst mwv", {31'b0, mwv}, 32'h0);
    chk("rst mwa_mwd", {16'b0, mwa, mwd}, 32'h0);
    chk("rst cwr", {28'b0, cwr}, 32'h0);
    chk("rst b_mrv", {30'b0, b_mrv}, 32'h0);
    reset = 1'b0;

    for (int k = 0; k < 23; k++) begin
      rv = vecs[k].rv; raddr = vecs[k].raddr; mrr = vecs[k].mrr; mrd = vecs[k].mrd;
      step();
      chk($sformatf("vec%0d mrv", k), {31'b0, mrv}, {31'b0, vecs[k].exp_mrv});
      if (vecs[k].exp_mrv) chk($sformatf("vec%0d mra", k), {24'b0, mra}, {24'b0, vecs[k].exp_mra});
      chk($sformatf("vec%0d crr", k), {28'b0, crr}, {28'b0, vecs[k].exp_crr});
      chk($sformatf("vec%0d crd", k), crd, vecs[k].exp_crd);
    end
    rv = '0; mrr = 1'b0; mrd = '0;

    // two channels, consumers 1 and 2 at once
    b_rv = 4'b0110; b_raddr = 32'h002A1B00;
    step();
    chk("dual mrv", {30'b0, b_mrv}, 32'h3);
    chk("dual mra", {16'b0, b_mra}, 32'h00002A1B);
    b_mrr = 2'b11; b_mrd = 16'hD2D1;
    step();
    chk("dual crr", {28'b0, b_crr}, 32'h6);
    chk("dual crd", b_crd, 32'h00D2D100);
    chk("dual mrv drop", {30'b0, b_mrv}, 32'h0);
    b_rv = '0; b_mrr = '0; b_mrd = '0;
    step();
    chk("dual release", {28'b0, b_crr}, 32'h0);

    // consumer 0 writes 0x77 to 0x40, memory stalls 5 cycles
    wv = 4'b0001; waddr = 32'h00000040; wdata = 32'h00000077;
    step();
`ifdef MEM_CTRL_WRITE_EN
    chk("wr mwv", {31'b0, mwv}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("wr stall%0d hold", k), {15'b0, mwv, mwa, mwd}, 32'h00014077);
      chk($sformatf("wr stall%0d cwr", k), {28'b0, cwr}, 32'h0);
    end
    mwr = 1'b1;
    step();
    chk("wr ack cwr", {28'b0, cwr}, 32'h1);
    chk("wr ack mwv", {31'b0, mwv}, 32'h0);
    mwr = 1'b0;
    step();
    chk("wr ack held", {28'b0, cwr}, 32'h1);
    wv = '0;
    step();
    chk("wr release", {28'b0, cwr}, 32'h0);
`else
    for (int k = 0; k < 6; k++) begin
      mwr = (k == 5);
      step();
      chk($sformatf("ro%0d mwv", k), {31'b0, mwv}, 32'h0);
      chk($sformatf("ro%0d cwr", k), {28'b0, cwr}, 32'h0);
      chk($sformatf("ro%0d mrv", k), {31'b0, mrv}, 32'h0);
    end
    mwr = 1'b0; wv = '0;
    step();
`endif

    // reset during READ_WAITING, then a fresh request
    rv = 4'b0010; raddr = 32'h00003100;
    step();
    chk("pre-rst mrv", {31'b0, mrv}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async rst mrv", {31'b0, mrv}, 32'h0);
    chk("async rst mra", {24'b0, mra}, 32'h0);
    step();
    #1 reset = 1'b0;
    step();
    chk("post-rst mrv", {31'b0, mrv}, 32'h1);
    chk("post-rst mra", {24'b0, mra}, 32'h31);
    mrr = 1'b1; mrd = 8'h6E;
    step();
    chk("post-rst crr", {28'b0, crr}, 32'h2);
    chk("post-rst crd", crd, 32'h00006E00);
    mrr = 1'b0; rv = '0;
    step();
    chk("post-rst release", {28'b0, crr}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
# mem_controller

Arbitrates the per-thread load/store requests of a core's LSUs onto a smaller number of external data-memory channels. It sits directly downstream of the LSUs: each LSU is one consumer port, and each memory channel carries at most one outstanding transaction. Read data and write acknowledgements are relayed back to the originating LSU.

## Interface
Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 4, number of LSU ports (≥1)
- NUM_CHANNELS, 1, number of memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- consumer_read_valid  in  NUM_CONSUMERS  read request per LSU
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  out  NUM_CONSUMERS  read data valid for consumer i
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
- consumer_write_valid  in  NUM_CONSUMERS  write request per LSU
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledged
- mem_read_valid  out  NUM_CHANNELS  read request per channel
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed
- mem_read_ready  in  NUM_CHANNELS  memory read response
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed
- mem_write_valid  out  NUM_CHANNELS
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS
- mem_write_data  out  NUM_CHANNELS*DATA_BITS
- mem_write_ready  in  NUM_CHANNELS

## Operation
- Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING. Each channel records which consumer it serves.
- A consumer is pending when its read or write valid is high and no channel currently serves it.
- IDLE: the channel claims the lowest-index pending consumer. Channels resolve in index order within one cycle, so a lower channel's claim hides that consumer from higher channels and no consumer is claimed twice. If read and write valid are both high, read wins.
- Read claim: latch the address, assert mem_read_valid, go to READ_WAITING. Write claim: latch address and data, assert mem_write_valid, go to WRITE_WAITING.
- READ_WAITING: on mem_read_ready, drop mem_read_valid, drive consumer_read_data with mem_read_data, assert consumer_read_ready, go to READ_RELAYING. WRITE_WAITING follows the same pattern with mem_write_ready and consumer_write_ready.
- RELAYING: hold ready and data until the served consumer's valid is sampled low. Then drop ready, free the consumer and return to IDLE. The consumer is claimable again on the following cycle.
- Consumer request signals are sampled only in IDLE. Changes while a transaction is in flight are ignored.
- Outputs for unserved consumers are 0.

## Timing
- All outputs are registered.
- Reset values: every ready, valid, address and data output is 0; all channels IDLE; no consumer is claimed.
- Request sampled at edge N gives mem_*_valid high after edge N. Memory ready sampled at edge M gives consumer ready high after edge M.
- Minimum round trip is 2 edges from request sampling to consumer ready when memory answers on the first valid cycle.
- Release takes 1 edge after the consumer drops valid.
- Memory handshake: valid is held, with stable address and data, until ready is sampled high.
- Reset asserted mid-transaction aborts it asynchronously. There is no replay; the LSU must re-request.
- Throughput: each channel handles one transaction per ≥3 cycles. Up to NUM_CHANNELS transactions are in flight.

## Configuration
- MEM_CTRL_WRITE_EN defined: write path as described above.
- MEM_CTRL_WRITE_EN undefined (read-only, e.g. program memory):
  - write ports remain on the module;
  - mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready are held 0;
  - write requests are never claimed;
  - the WRITE_* states are not built.

## Structure
- Shared package gpu_pkg:
  - default ADDR_BITS and DATA_BITS;
  - channel state enum mem_ctrl_state_t (IDLE=3'd0, READ_WAITING=3'd1, WRITE_WAITING=3'd2, READ_RELAYING=3'd3, WRITE_RELAYING=3'd4).
- Sub-module mem_ctrl_channel: one FSM plus its latched address/data, instantiated NUM_CHANNELS times.
- The claim and mask logic and the packing/unpacking of consumer-side outputs stay in the top level.

## Test plan
- NUM_CHANNELS=1. Consumer 2 reads address 0x1A; memory returns 0x5C one cycle after valid. Expect mem_read_address=0x1A, then consumer_read_ready[2]=1 with data 0x5C. Expect release 1 cycle after the consumer drops valid.
- Consumers 0, 1 and 3 raise read valid in the same cycle, with one channel. Expect service in order 0, 1, 3, one transaction at a time, with no overlap of mem_read_valid between them.
- NUM_CHANNELS=2, consumers 1 and 2 request together. Expect channel 0 to serve consumer 1 and channel 1 to serve consumer 2 in the same cycle, with no duplicate grant.
- With MEM_CTRL_WRITE_EN defined, consumer 0 writes 0x77 to 0x40 and memory stalls ready for 5 cycles. Expect the write valid, address and data held stable for the whole stall, then consumer_write_ready[0]. With the macro undefined, the same stimulus never produces mem_write_valid or consumer_write_ready.
- Assert reset while READ_WAITING. Expect all outputs 0 immediately without waiting for a clock edge; after reset is released, a fresh request is served normally.
- The consumer holds valid for 4 cycles after ready is asserted. Expect consumer_read_ready and the read data to stay stable for those 4 cycles, and no new claim of that consumer until after release.
